// File: rtl/frame_cycle_counter.sv
`default_nettype none
// ============================================================================
// frame_cycle_counter : two-level fast/slow cycle sequencer with frame shadows
// Revision: 1.0
// ============================================================================
module frame_cycle_counter #(
    parameter int FAST_COUNT_WIDTH  = 13,
    parameter int SLOW_COUNT_WIDTH  = 19,
    parameter int FRAME_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclr,
    input  logic                         clken,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         continuous,
    input  logic [FAST_COUNT_WIDTH-1:0]  fast_max,
    input  logic [SLOW_COUNT_WIDTH-1:0]  slow_max,
    output logic                         running,
    output logic                         done,
    output logic [FAST_COUNT_WIDTH-1:0]  fast_count,
    output logic [SLOW_COUNT_WIDTH-1:0]  slow_count,
    output logic                         end_cycle,
    output logic                         end_frame,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [FAST_COUNT_WIDTH-1:0]  FAST_ONE  = {{(FAST_COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SLOW_COUNT_WIDTH-1:0]  SLOW_ONE  = {{(SLOW_COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FRAME_COUNT_WIDTH-1:0] FRAME_ONE = {{(FRAME_COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                         state, state_nxt;
    logic [FAST_COUNT_WIDTH-1:0]    fast_cnt, fast_cnt_nxt;
    logic [SLOW_COUNT_WIDTH-1:0]    slow_cnt, slow_cnt_nxt;
    logic [FRAME_COUNT_WIDTH-1:0]   frame_cnt, frame_cnt_nxt;
    logic [FAST_COUNT_WIDTH-1:0]    fast_max_a, fast_max_a_nxt;
    logic [SLOW_COUNT_WIDTH-1:0]    slow_max_a, slow_max_a_nxt;
    logic                           cont_a, cont_a_nxt;
    logic                           fast_last, slow_last;

    assign fast_last = (fast_cnt == fast_max_a);
    assign slow_last = (slow_cnt == slow_max_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fast_cnt   <= '0;
            slow_cnt   <= '0;
            frame_cnt  <= '0;
            fast_max_a <= '0;
            slow_max_a <= '0;
            cont_a     <= 1'b0;
        end else begin
            state      <= state_nxt;
            fast_cnt   <= fast_cnt_nxt;
            slow_cnt   <= slow_cnt_nxt;
            frame_cnt  <= frame_cnt_nxt;
            fast_max_a <= fast_max_a_nxt;
            slow_max_a <= slow_max_a_nxt;
            cont_a     <= cont_a_nxt;
        end
    end

    // Priority: sclr > stop > frame wrap > start
    always_comb begin
        state_nxt      = state;
        fast_cnt_nxt   = fast_cnt;
        slow_cnt_nxt   = slow_cnt;
        frame_cnt_nxt  = frame_cnt;
        fast_max_a_nxt = fast_max_a;
        slow_max_a_nxt = slow_max_a;
        cont_a_nxt     = cont_a;
        if (sclr) begin
            state_nxt     = IDLE;
            fast_cnt_nxt  = '0;
            slow_cnt_nxt  = '0;
            frame_cnt_nxt = '0;
        end else begin
            case (state)
                RUN: begin
                    if (stop) begin
                        state_nxt    = IDLE;
                        fast_cnt_nxt = '0;
                        slow_cnt_nxt = '0;
                    end else if (clken) begin
                        if (!fast_last) begin
                            fast_cnt_nxt = fast_cnt + FAST_ONE;
                        end else begin
                            fast_cnt_nxt = '0;
                            if (!slow_last) begin
                                slow_cnt_nxt = slow_cnt + SLOW_ONE;
                            end else begin
                                slow_cnt_nxt  = '0;
                                frame_cnt_nxt = frame_cnt + FRAME_ONE;
                                if (cont_a) begin
                                    fast_max_a_nxt = fast_max;
                                    slow_max_a_nxt = slow_max;
                                    cont_a_nxt     = continuous;
                                end else begin
                                    state_nxt = DONE;
                                end
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                    fast_cnt_nxt = '0;
                    slow_cnt_nxt = '0;
                    if (start) begin
                        state_nxt      = RUN;
                        fast_max_a_nxt = fast_max;
                        slow_max_a_nxt = slow_max;
                        cont_a_nxt     = continuous;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    fast_cnt_nxt = '0;
                    slow_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Flags decode registered state only; no input reaches them combinationally.
    assign running     = (state == RUN);
    assign done        = (state == DONE);
    assign fast_count  = fast_cnt;
    assign slow_count  = slow_cnt;
    assign frame_count = frame_cnt;
    assign end_cycle   = running && fast_last;
    assign end_frame   = end_cycle && slow_last;

endmodule
`default_nettype wire

// File: tb/tb_frame_cycle_counter.sv
`default_nettype none
// ============================================================================
// tb_frame_cycle_counter : directed self-checking bench for frame_cycle_counter
// Revision: 1.0
// ============================================================================
module tb_frame_cycle_counter;

    logic        clk = 1'b0;
    logic        rst, sclr, clken, start, stop, continuous;
    logic [12:0] fast_max, fast_count;
    logic [18:0] slow_max, slow_count;
    logic        running, done, end_cycle, end_frame;
    logic [31:0] frame_count;

    int tests_run    = 0;
    int tests_failed = 0;

    frame_cycle_counter #(
        .FAST_COUNT_WIDTH (13),
        .SLOW_COUNT_WIDTH (19),
        .FRAME_COUNT_WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclr       (sclr),
        .clken      (clken),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .fast_max   (fast_max),
        .slow_max   (slow_max),
        .running    (running),
        .done       (done),
        .fast_count (fast_count),
        .slow_count (slow_count),
        .end_cycle  (end_cycle),
        .end_frame  (end_frame),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int fc, input int sc, input bit ec, input bit ef);
        check({tag, " running"},   {31'd0, running},    32'd1);
        check({tag, " fast"},      {19'd0, fast_count}, fc);
        check({tag, " slow"},      {13'd0, slow_count}, sc);
        check({tag, " end_cycle"}, {31'd0, end_cycle},  {31'd0, ec});
        check({tag, " end_frame"}, {31'd0, end_frame},  {31'd0, ef});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sclr = 1'b0; clken = 1'b1; start = 1'b0; stop = 1'b0;
        continuous = 1'b0; fast_max = '0; slow_max = '0;
        step(); step();
        check("rst running", {31'd0, running}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst frames", frame_count, 32'd0);
        check("rst end_cycle", {31'd0, end_cycle}, 32'd0);
        rst = 1'b0;
        step();
        check("idle running", {31'd0, running}, 32'd0);

        // One-shot 4 x 3 frame
        fast_max = 13'd3; slow_max = 19'd2; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_pos("oneshot", i % 4, i / 4, (i % 4) == 3, i == 11);
            step();
        end
        check("oneshot done", {31'd0, done}, 32'd1);
        check("oneshot running", {31'd0, running}, 32'd0);
        check("oneshot end_frame", {31'd0, end_frame}, 32'd0);
        check("oneshot frames", frame_count, 32'd1);

        // Continuous with mid-frame max change
        fast_max = 13'd1; slow_max = 19'd1; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("restart done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_pos("cont f1", i % 2, i / 2, (i % 2) == 1, i == 3);
            if (i == 0) fast_max = 13'd2;
            step();
        end
        check("cont f1 frames", frame_count, 32'd2);
        for (int i = 0; i < 6; i++) begin
            check_pos("cont f2", i % 3, i / 3, (i % 3) == 2, i == 5);
            if (i == 0) continuous = 1'b0;
            step();
        end
        check("cont f2 frames", frame_count, 32'd3);
        for (int i = 0; i < 5; i++) begin
            check_pos("cont f3", i % 3, i / 3, (i % 3) == 2, 1'b0);
            step();
        end
        check_pos("pre-stop", 2, 1, 1'b1, 1'b1);

        // Stop beats the frame wrap
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop running", {31'd0, running}, 32'd0);
        check("stop done", {31'd0, done}, 32'd0);
        check("stop fast", {19'd0, fast_count}, 32'd0);
        check("stop slow", {13'd0, slow_count}, 32'd0);
        check("stop frames", frame_count, 32'd3);

        // sclr beats start
        start = 1'b1; sclr = 1'b1;
        step();
        start = 1'b0; sclr = 1'b0;
        check("sclr running", {31'd0, running}, 32'd0);
        check("sclr frames", frame_count, 32'd0);

        // start with stop from IDLE enters RUN; then clken gaps
        fast_max = 13'd2; slow_max = 19'd0; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_pos("gap c0", 0, 0, 1'b0, 1'b0);
        step();
        check_pos("gap c1", 1, 0, 1'b0, 1'b0);
        clken = 1'b0;
        step(); step();
        check_pos("gap hold", 1, 0, 1'b0, 1'b0);
        clken = 1'b1;
        step();
        check_pos("gap c2", 2, 0, 1'b1, 1'b1);
        clken = 1'b0;
        step();
        check_pos("gap hold end", 2, 0, 1'b1, 1'b1);
        clken = 1'b1;
        step();
        check("gap done", {31'd0, done}, 32'd1);
        check("gap frames", frame_count, 32'd1);

        // Degenerate fast_max = 0
        fast_max = 13'd0; slow_max = 19'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_pos("degen", 0, i, 1'b1, i == 4);
            step();
        end
        check("degen done", {31'd0, done}, 32'd1);
        check("degen frames", frame_count, 32'd2);

        // sclr from DONE
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        check("sclr done", {31'd0, done}, 32'd0);
        check("sclr frames2", frame_count, 32'd0);

        // Asynchronous reset mid-RUN
        fast_max = 13'd3; slow_max = 19'd2; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check_pos("pre-rst", 2, 0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst running", {31'd0, running}, 32'd0);
        check("arst fast", {19'd0, fast_count}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        start = 1'b0;
        check_pos("post-rst", 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_cycle_counter.md
# frame_cycle_counter

Two-level cycle sequencer: a fast counter runs 0..fast_max, and a slow counter advances once per fast wrap and runs 0..slow_max, so one frame is (fast_max+1)*(slow_max+1) enabled cycles. Compared with the single-shot cycle counter it adds:
- start/stop control
- one-shot or continuous mode
- a bounded slow count
- frame-boundary shadowing of the max values
- end-of-frame/done flags and a frame counter

It sits between the DSP sample clock-enable and the acquisition/averaging logic that consumes cycle and frame boundaries.

## Interface
Parameters:
- FAST_COUNT_WIDTH, 13, width of fast_count and fast_max
- SLOW_COUNT_WIDTH, 19, width of slow_count and slow_max
- FRAME_COUNT_WIDTH, 32, width of frame_count

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous and active-high; forces every register to its reset value
- sclr  in  1  synchronous clear; returns to IDLE, clears counters, done and frame_count
- clken  in  1  count enable; counters advance only when high
- start  in  1  level-sampled; in IDLE or DONE, loads shadows and enters RUN
- stop  in  1  in RUN, abort to IDLE next edge
- continuous  in  1  mode, sampled at start and at each frame wrap; 1 = restart frames automatically
- fast_max  in  FAST_COUNT_WIDTH  last fast_count value
- slow_max  in  SLOW_COUNT_WIDTH  last slow_count value
- running  out  1  high in RUN
- done  out  1  high in DONE
- fast_count  out  FAST_COUNT_WIDTH  current fast index
- slow_count  out  SLOW_COUNT_WIDTH  current slow index
- end_cycle  out  1  RUN and fast_count==fast_max_a
- end_frame  out  1  end_cycle and slow_count==slow_max_a
- frame_count  out  FRAME_COUNT_WIDTH  completed frames, wraps modulo 2^FRAME_COUNT_WIDTH

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - DONE
- Shadow registers fast_max_a, slow_max_a and cont_a:
  - load from the inputs on any start that is accepted;
  - in continuous mode, reload at each frame wrap;
  - the inputs never affect a frame in progress.
- Priority per edge: sclr > stop > frame wrap > start.
- IDLE:
  - fast_count=0, slow_count=0, running=0.
  - start -> RUN (shadows loaded, counters 0).
- RUN, clken high:
  - if fast_count != fast_max_a: fast_count+1.
  - else fast_count=0, and
    - if slow_count != slow_max_a: slow_count+1;
    - else (frame wrap) slow_count=0, frame_count+1, and
      - if cont_a=1: stay in RUN and reload shadows (cont_a from continuous);
      - otherwise: go to DONE.
- RUN, clken low: all registers hold; end_cycle/end_frame hold their level.
- stop in RUN:
  - IDLE at the next edge, counters 0;
  - frame_count is not incremented, done is not set.
  - stop outside RUN has no effect.
- start while in RUN is ignored.
- DONE:
  - done=1, counters 0.
  - start -> RUN, done=0, frame_count kept.
  - sclr -> IDLE.
- end_cycle and end_frame are decodes of registered state only, with no combinational path from the inputs. They are 0 outside RUN.
- Boundary cases:
  - fast_max=0: end_cycle stays high for the whole of RUN, and slow_count advances on every clken cycle.
  - fast_max=0 and slow_max=0: every enabled cycle is a frame wrap.
- Counter arithmetic wraps only at the programmed max, never at 2^WIDTH−1 unless max is all-ones.

## Timing
- Reset values: running=0, done=0, fast_count=0, slow_count=0, end_cycle=0, end_frame=0, frame_count=0, state IDLE, shadows 0.
- start sampled at edge N:
  - running=1 and counters 0 after edge N;
  - first increment at the first edge >N with clken=1.
- end_cycle is high after the edge where fast_count reaches fast_max_a. It is high for exactly one enabled cycle.
- One-shot:
  - after the wrap edge: done=1, running=0, end_frame=0;
  - frame_count has already been incremented on that same edge.
- Continuous: no dead cycle between frames. The first fast_count=0 of frame k+1 directly follows end_frame of frame k.
- rst mid-operation: outputs reach their reset values immediately (asynchronous); the first start accepted is on the first edge after deassert.

## Test plan
- One-shot:
  - Stimulus: rst pulse, fast_max=3, slow_max=2, continuous=0, clken=1, start for 1 cycle.
  - Response: 12 enabled cycles; end_cycle high at fast_count=3 for slow_count 0,1,2; end_frame only at (3,2); next edge done=1, running=0, frame_count=1.
- Continuous with shadowing:
  - Stimulus: fast_max=1, slow_max=1, continuous=1; change fast_max to 2 mid-frame.
  - Response: frame 1 lasts 4 cycles; frame 2 lasts 6 cycles; no gap between frames; frame_count increments 1, 2.
- Clock-enable gaps:
  - Stimulus: clken pattern 1,0,0,1 with fast_max=2, slow_max=0, one-shot.
  - Response: counters and end_cycle hold during clken=0; done after 3 enabled cycles.
- Degenerate max:
  - Stimulus: fast_max=0, slow_max=4, one-shot.
  - Response: end_cycle constantly 1 in RUN; slow_count steps 0..4 on consecutive edges; done after 5 cycles.
- Abort, clear and priority:
  - Stimulus: stop at fast_count=2, slow_count=1.
  - Response: IDLE and counters 0 next edge, frame_count unchanged, done=0.
  - Stimulus: start with sclr in the same cycle.
  - Response: stays IDLE.
  - Stimulus: start with stop in the same cycle, from IDLE.
  - Response: enters RUN.
- Async reset:
  - Stimulus: rst asserted between edges during RUN.
  - Response: all outputs 0 before the next edge; start accepted on the first edge after deassert.
